// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, instruction width, reset NOP.
package rv_fetch_pkg;

   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN,
      WAIT,
      DROP
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus and fetch-to-core valid/ready bus.
interface imem_if #(parameter int XLEN = 32);
   import rv_fetch_pkg::*;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [ILEN-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

interface fetch_if #(parameter int XLEN = 32);
   import rv_fetch_pkg::*;

   logic            valid;
   logic            ready;
   logic [XLEN-1:0] pc;
   logic [ILEN-1:0] instr;

   modport master (output valid, pc, instr, input ready);
   modport slave  (input valid, pc, instr, output ready);
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch buffer: registered write, combinational head, sync flush; 1-cycle push-to-visible.
// Push while full is taken only together with a pop; pop while empty is ignored.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: only entries covered by cnt_q are ever presented.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC owner, one-outstanding imem reads into a prefetch FIFO; rvalid->fetch_valid 1 cycle.
// Requests stop while buffered+in-flight words fill the FIFO; FETCH_MISALIGN_CHECK_EN adds fetch_misalign.
module instr_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   imem_if.master          imem,
   fetch_if.master         fetch,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic            fetch_misalign
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] tgt_pc;
   logic            req_q;
   logic            issued;
   logic            busy_after;
   logic            credit;
   logic            idle_nxt;
   logic            push;
   logic            pop;
   logic            empty;
   logic            fifo_full_unused;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   fetch_entry_t    push_dat;
   fetch_entry_t    head;

   assign tgt_pc = {redirect_pc[XLEN-1:2], 2'b00};
   assign issued = req_q & imem.gnt;
   assign pop    = ~empty & fetch.ready;
   assign push   = imem.rvalid & (state_q == WAIT) & ~redirect_valid;
   // pc_q already stepped past the word in flight when it was granted.
   assign push_dat  = '{pc: pc_q - XLEN'(4), instr: imem.rdata};
   assign count_nxt = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
   assign credit    = (count_nxt < DEPTH_C) & ~idle_nxt;

   // A read is still owed after this edge unless its rvalid lands in this very cycle.
   assign busy_after = ((state_q == WAIT || state_q == DROP) && !imem.rvalid) || issued;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              misalign_q <= 1'b0;
      else if (redirect_valid) misalign_q <= |redirect_pc[1:0];
   end

   assign fetch_misalign = misalign_q;
   assign idle_nxt       = redirect_valid ? |redirect_pc[1:0] : misalign_q;
`else
   logic unused_lsb;
   assign unused_lsb = ^redirect_pc[1:0];
   assign idle_nxt   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
      end else if (redirect_valid) begin
         pc_q    <= tgt_pc;
         req_q   <= 1'b0;
         state_q <= busy_after ? DROP : RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (issued) begin
                  pc_q    <= pc_q + XLEN'(4);
                  req_q   <= 1'b0;
                  state_q <= WAIT;
               end else begin
                  req_q <= credit;
               end
            end
            WAIT, DROP: begin
               if (imem.rvalid) begin
                  state_q <= RUN;
                  req_q   <= credit;
               end
            end
            default: begin
               state_q <= RUN;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .pop_dat  (head),
      .full     (fifo_full_unused),
      .empty    (empty),
      .count    (count)
   );

   assign imem.req    = req_q;
   assign imem.addr   = pc_q;
   assign fetch.valid = ~empty;
   assign fetch.pc    = empty ? '0 : head.pc;
   assign fetch.instr = empty ? NOP_INSTR : head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory model, PC model and expected-word queue.
module tb_instr_fetch_unit;
   import rv_fetch_pkg::*;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misalign;
`endif

   always #5 clk = ~clk;

   imem_if  #(.XLEN(XLEN)) imem_bus ();
   fetch_if #(.XLEN(XLEN)) fetch_bus ();

   instr_fetch_unit #(
      .XLEN       (XLEN),
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (imem_bus),
      .fetch          (fetch_bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } rd_t;

   exp_t        sb[$];
   rd_t         pend[$];
   logic [31:0] pop_log[$];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lat = 1;
   int          req_seen = 0;
   logic [31:0] exp_addr = RESET_PC;
   logic [31:0] redir_tgt = 32'h0;
   bit          ready_en = 1'b1;
   bit          gnt_en = 1'b1;
   bit          redir_req = 1'b0;
   bit          redir_on_rv = 1'b0;
   bit          hit4 = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] logged(input int i);
      if (i < pop_log.size()) return pop_log[i];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock of bench activity: observe at the falling edge, then drive for the next rising edge.
   task automatic step();
      bit          redir;
      bit          rdy;
      bit          rv;
      bit          g;
      rd_t         rd;
      exp_t        e;
      logic [31:0] rdata_v;

      @(negedge clk);
      cyc++;
      check_eq("valid_vs_sb", 32'(fetch_bus.valid), 32'(sb.size() != 0));
      if (imem_bus.req) req_seen++;

      rv      = 1'b0;
      rdata_v = 32'hDEAD_BEEF;
      rd      = '{32'h0, 0, 1'b0};
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         rd      = pend.pop_front();
         rv      = 1'b1;
         rdata_v = mem_word(rd.addr);
      end

      redir = redir_req;
      rdy   = ready_en;
      if (redir_on_rv && rv && fetch_bus.valid) begin
         redir       = 1'b1;
         rdy         = 1'b1;
         redir_on_rv = 1'b0;
         hit4        = 1'b1;
      end
      redir_req = 1'b0;

      if (fetch_bus.valid && rdy && sb.size() != 0) begin
         e = sb.pop_front();
         check_eq("fetch_pc", fetch_bus.pc, e.pc);
         check_eq("fetch_instr", fetch_bus.instr, e.instr);
         pop_log.push_back(fetch_bus.pc);
      end

      if (rv && !rd.stale && !redir) sb.push_back('{rd.addr, rdata_v});

      g = imem_bus.req && gnt_en;
      if (g) begin
         check_eq("one_outstanding", 32'(pend.size()), 32'd0);
         check_eq("imem_addr", imem_bus.addr, exp_addr);
         pend.push_back('{imem_bus.addr, cyc + lat, 1'b0});
         exp_addr = exp_addr + 32'd4;
      end

      if (redir) begin
         sb.delete();
         pop_log.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_addr = {redir_tgt[31:2], 2'b00};
      end

      imem_bus.gnt    = g;
      imem_bus.rvalid = rv;
      imem_bus.rdata  = rdata_v;
      fetch_bus.ready = rdy;
      redirect_valid  = redir;
      redirect_pc     = redir ? redir_tgt : 32'h0BAD_0BAD;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      imem_bus.gnt    = 1'b0;
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = 32'h0;
      fetch_bus.ready = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;

      repeat (3) @(negedge clk);
      check_eq("rst_req", 32'(imem_bus.req), 32'd0);
      check_eq("rst_addr", imem_bus.addr, RESET_PC);
      check_eq("rst_valid", 32'(fetch_bus.valid), 32'd0);
      check_eq("rst_pc", fetch_bus.pc, 32'h0);
      check_eq("rst_instr", fetch_bus.instr, NOP_INSTR);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("first_req", 32'(imem_bus.req), 32'd1);
      check_eq("first_addr", imem_bus.addr, RESET_PC);

      // Streaming in order with a always-ready core
      ready_en = 1'b1;
      repeat (30) step();
      check_eq("t1_progress", 32'(pop_log.size() >= 10), 32'd1);
      check_eq("t1_pc0", logged(0), 32'h0);
      check_eq("t1_pc1", logged(1), 32'h4);
      check_eq("t1_pc2", logged(2), 32'h8);

      // Core stall: buffer fills to depth and requests stop
      ready_en = 1'b0;
      repeat (20) step();
      check_eq("t2_buffered", 32'(sb.size()), 32'd4);
      check_eq("t2_req_off", 32'(imem_bus.req), 32'd0);
      check_eq("t2_valid", 32'(fetch_bus.valid), 32'd1);
      ready_en = 1'b1;
      repeat (20) step();
      check_eq("t2_drained", 32'(sb.size() <= 1), 32'd1);

      // Redirect while a read is outstanding
      lat = 3;
      for (int i = 0; i < 20 && pend.size() == 0; i++) step();
      check_eq("t3_inflight", 32'(pend.size()), 32'd1);
      redir_tgt = 32'h0000_0100;
      redir_req = 1'b1;
      step();
      step();
      check_eq("t3_flush", 32'(fetch_bus.valid), 32'd0);
      lat = 1;
      repeat (20) step();
      check_eq("t3_pc0", logged(0), 32'h100);
      check_eq("t3_pc1", logged(1), 32'h104);

      // Redirect coinciding with rvalid and a completing handshake
      ready_en    = 1'b0;
      redir_tgt   = 32'h0000_0240;
      hit4        = 1'b0;
      redir_on_rv = 1'b1;
      for (int i = 0; i < 60 && !hit4; i++) step();
      check_eq("t4_hit", 32'(hit4), 32'd1);
      redir_on_rv = 1'b0;
      step();
      check_eq("t4_addr", imem_bus.addr, 32'h0000_0240);
      check_eq("t4_flush", 32'(fetch_bus.valid), 32'd0);
      ready_en = 1'b1;
      repeat (20) step();
      check_eq("t4_pc0", logged(0), 32'h240);

      // Address wrap at the top of the space
      redir_tgt = 32'hFFFF_FFFC;
      redir_req = 1'b1;
      repeat (20) step();
      check_eq("t5_pc0", logged(0), 32'hFFFF_FFFC);
      check_eq("t5_pc1", logged(1), 32'h0000_0000);
      check_eq("t5_pc2", logged(2), 32'h0000_0004);

`ifdef FETCH_MISALIGN_CHECK_EN
      redir_tgt = 32'h0000_0102;
      redir_req = 1'b1;
      step();
      req_seen = 0;
      repeat (12) step();
      check_eq("t6_misalign_set", 32'(fetch_misalign), 32'd1);
      check_eq("t6_no_req", 32'(req_seen), 32'd0);
      check_eq("t6_empty", 32'(sb.size()), 32'd0);
      redir_tgt = 32'h0000_0200;
      redir_req = 1'b1;
      step();
      step();
      check_eq("t6_misalign_clr", 32'(fetch_misalign), 32'd0);
      repeat (20) step();
      check_eq("t6_pc0", logged(0), 32'h200);
`else
      redir_tgt = 32'h0000_0102;
      redir_req = 1'b1;
      repeat (20) step();
      check_eq("t6_forced_align", logged(0), 32'h100);
      check_eq("t6_forced_next", logged(1), 32'h104);
`endif

      // Random core backpressure and grant gaps
      for (int i = 0; i < 200; i++) begin
         ready_en = 1'($urandom_range(0, 1));
         gnt_en   = 1'($urandom_range(0, 3) != 0);
         lat      = int'($urandom_range(1, 3));
         step();
      end
      gnt_en   = 1'b1;
      ready_en = 1'b1;
      lat      = 1;
      repeat (10) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
